// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared core constants (NOP, opcodes) and fetch state encoding
package inst_fetch_pkg;
    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetch_state_e;
endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch with stall buffer and redirect drain
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic [31:0] inst,
    output logic [63:0] PC_o,
    output logic        inst_valid,
    output logic [31:0] fetch_count
);
    fetch_state_e state, state_n;
    logic [63:0] pc, pc_n, req_addr, req_addr_n, buf_pc, buf_pc_n, pc_o_n;
    logic [31:0] buf_inst, buf_inst_n, inst_n, count_n;
    logic        valid_n;

    assign imem_req  = !reset && state != HOLD;
    assign imem_addr = req_addr;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        inst_n     = inst;
        pc_o_n     = PC_o;
        valid_n    = inst_valid;
        count_n    = fetch_count;
        buf_inst_n = buf_inst;
        buf_pc_n   = buf_pc;
        if (redirect_en) begin
            // an unacknowledged request must still be drained before refetching
            state_n    = (state != HOLD && !imem_ack) ? DRAIN : FETCH;
            pc_n       = redirect_pc & ~64'h3;
            inst_n     = NOP;
            valid_n    = 1'b0;
            buf_inst_n = '0;
            buf_pc_n   = '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        pc_n = req_addr + 64'd4;
                        if (stall) begin
                            buf_inst_n = imem_rdata;
                            buf_pc_n   = req_addr;
                            state_n    = HOLD;
                        end else begin
                            inst_n  = imem_rdata;
                            pc_o_n  = req_addr;
                            valid_n = 1'b1;
                            count_n = fetch_count + 32'd1;
                        end
                    end else if (!stall) begin
                        inst_n  = NOP;
                        valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        inst_n  = buf_inst;
                        pc_o_n  = buf_pc;
                        valid_n = 1'b1;
                        count_n = fetch_count + 32'd1;
                        state_n = FETCH;
                    end
                end
                default: state_n = imem_ack ? FETCH : DRAIN;
            endcase
        end
        req_addr_n = state_n == FETCH ? pc_n : req_addr;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            inst        <= NOP;
            PC_o        <= '0;
            inst_valid  <= 1'b0;
            fetch_count <= '0;
            buf_inst    <= '0;
            buf_pc      <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            req_addr    <= req_addr_n;
            inst        <= inst_n;
            PC_o        <= pc_o_n;
            inst_valid  <= valid_n;
            fetch_count <= count_n;
            buf_inst    <= buf_inst_n;
            buf_pc      <= buf_pc_n;
        end
    end
endmodule
